// File: rtl/adder_collector_pkg.sv
// Shared definitions for the adder result collector.
//   W_DEF / DEPTH_DEF / ERR_W_DEF : default operand width, FIFO depth and
//                                   mismatch counter width
//   result_entry_t                : FIFO entry layout {cout, sum, mismatch}
//   stage_state_e                 : operand stage state (EMPTY / LOADED)
package adder_collector_pkg;

  localparam int W_DEF     = 4;
  localparam int DEPTH_DEF = 4;
  localparam int ERR_W_DEF = 8;

  typedef struct packed {
    logic             cout;
    logic [W_DEF-1:0] sum;
    logic             mismatch;
  } result_entry_t;

  typedef enum logic {
    S_EMPTY  = 1'b0,
    S_LOADED = 1'b1
  } stage_state_e;

endpackage

// File: rtl/adder_result_collector_if.sv
// Bundle of all handshake, adder and status signals of the collector.
//   operand side : i_valid, o_ready, i_add_term1, i_add_term2
//   adder side   : add_a, add_b (to adder), add_sum, add_cout (from adder)
//   result side  : o_valid, i_ready, o_sum, o_cout, o_mismatch
//   status       : err_cnt, clear
// Modport slave is the collector; master is whoever drives it (bench/top).
interface adder_result_collector_if
  import adder_collector_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int ERR_W = ERR_W_DEF
);

  logic             i_valid;
  logic             o_ready;
  logic [W-1:0]     i_add_term1;
  logic [W-1:0]     i_add_term2;
  logic [W-1:0]     add_a;
  logic [W-1:0]     add_b;
  logic [W-1:0]     add_sum;
  logic             add_cout;
  logic             o_valid;
  logic             i_ready;
  logic [W-1:0]     o_sum;
  logic             o_cout;
  logic             o_mismatch;
  logic [ERR_W-1:0] err_cnt;
  logic             clear;

  modport slave (
    input  i_valid, i_add_term1, i_add_term2, add_sum, add_cout, i_ready, clear,
    output o_ready, add_a, add_b, o_valid, o_sum, o_cout, o_mismatch, err_cnt
  );

  modport master (
    output i_valid, i_add_term1, i_add_term2, add_sum, add_cout, i_ready, clear,
    input  o_ready, add_a, add_b, o_valid, o_sum, o_cout, o_mismatch, err_cnt
  );

endinterface

// File: rtl/adder_result_collector_fifo.sv
// result_fifo: power-of-two deep FIFO holding collector results.
//   clk, rst_n : clock, async active-low reset (pointers/count cleared)
//   push/wdata : write request; ignored when full unless a pop frees a slot
//   pop        : read request; ignored when empty
//   rdata      : head entry (valid while !empty)
//   count      : occupancy 0..DEPTH
//   empty      : count == 0
module result_fifo
  import adder_collector_pkg::*;
#(
  parameter int  DEPTH = DEPTH_DEF,
  parameter type T     = result_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  T                       wdata,
  input  logic                   pop,
  output T                       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full, do_push, do_pop;

  always_comb begin
    full    = (count_q == (AW+1)'(DEPTH));
    empty   = (count_q == '0);
    do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO would need.
    do_push = push && (!full || do_pop);

    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    // Pointers wrap naturally: DEPTH is a power of two.
    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    rdata = mem_q[rptr_q];
    count = count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/adder_result_collector.sv
// adder_result_collector: registers operands for an external adder, checks
// the adder's result against a golden sum one cycle later and queues
// {cout, sum, mismatch} in a result FIFO.
//   clk, rst_n : clock, async active-low reset
//   bus.slave  : operand handshake (i_valid/o_ready, i_add_term1/2),
//                adder link (add_a/add_b out, add_sum/add_cout in),
//                result handshake (o_valid/i_ready, o_sum/o_cout/o_mismatch),
//                err_cnt (saturating mismatch count) and clear
module adder_result_collector
  import adder_collector_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ERR_W = ERR_W_DEF
) (
  input logic                    clk,
  input logic                    rst_n,
  adder_result_collector_if.slave bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Same layout as result_entry_t, sized for this instance's W.
  typedef struct packed {
    logic         cout;
    logic [W-1:0] sum;
    logic         mismatch;
  } entry_t;

  stage_state_e     state_q, state_d;
  logic [W-1:0]     add_a_q, add_a_d;
  logic [W-1:0]     add_b_q, add_b_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             loaded, accept, push, pop, mismatch, fifo_empty;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      occupancy;
  logic [W:0]       golden;
  entry_t           wdata, rdata;

  always_comb begin
    loaded = (state_q == S_LOADED);

    // The in-flight LOADED result has a reserved slot, so a push can never
    // find the FIFO full.
    occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, loaded};
    bus.o_ready = (occupancy < (CW+1)'(DEPTH));
    accept      = bus.i_valid && bus.o_ready;

    state_d = accept ? S_LOADED : S_EMPTY;
    add_a_d = add_a_q;
    add_b_d = add_b_q;
    if (accept) begin
      add_a_d = bus.i_add_term1;
      add_b_d = bus.i_add_term2;
    end

    // Adder output settles during the LOADED cycle; capture it then.
    golden         = {1'b0, add_a_q} + {1'b0, add_b_q};
    mismatch       = ({bus.add_cout, bus.add_sum} != golden);
    push           = loaded;
    wdata.cout     = bus.add_cout;
    wdata.sum      = bus.add_sum;
    wdata.mismatch = mismatch;

    bus.o_valid = !fifo_empty;
    pop         = bus.o_valid && bus.i_ready;
    // Gate the head so outputs read zero whenever nothing is queued.
    bus.o_sum      = bus.o_valid ? rdata.sum      : '0;
    bus.o_cout     = bus.o_valid ? rdata.cout     : 1'b0;
    bus.o_mismatch = bus.o_valid ? rdata.mismatch : 1'b0;

    err_cnt_d = err_cnt_q;
    if (bus.clear)
      err_cnt_d = '0;
    else if (push && mismatch && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_W'(1);

    bus.add_a   = add_a_q;
    bus.add_b   = add_b_q;
    bus.err_cnt = err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_EMPTY;
      add_a_q   <= '0;
      add_b_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  result_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_adder_result_collector.sv
// Scoreboard bench for adder_result_collector: accepted operands produce an
// expected result (from arithmetic on the operands and the adder fault mode)
// queued for a monitor that compares every popped FIFO head.
module tb_adder_result_collector;
  import adder_collector_pkg::*;

  localparam int W     = 4;
  localparam int DEPTH = 4;
  localparam int ERR_W = 8;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_result_collector_if #(.W(W), .ERR_W(ERR_W)) bus ();

  adder_result_collector #(.W(W), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // External adder, optionally with sum bit 0 stuck at 0.
  logic       stuck0 = 1'b0;
  logic [W:0] adder_true;
  assign adder_true   = {1'b0, bus.add_a} + {1'b0, bus.add_b};
  assign bus.add_sum  = stuck0 ? {adder_true[W-1:1], 1'b0} : adder_true[W-1:0];
  assign bus.add_cout = adder_true[W];

  typedef struct {
    int sum;
    int cout;
    int mm;
  } exp_t;

  exp_t q[$];
  int   checks = 0, errors = 0;
  int   accepts = 0, pops = 0, err_exp = 0;
  int   cyc = 0, last_pop_cyc = 0, prev_pop_cyc = 0;

  always @(posedge clk) cyc++;

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor / scoreboard
  exp_t e;
  int   m_true, m_obs;
  logic hold_prev = 1'b0;
  int   prev_sum, prev_cout, prev_mm;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", int'(bus.o_valid), 1);
        check("hold_sum",   int'(bus.o_sum), prev_sum);
        check("hold_cout",  int'(bus.o_cout), prev_cout);
        check("hold_mm",    int'(bus.o_mismatch), prev_mm);
      end
      if (bus.o_valid && bus.i_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum %0d with nothing expected", bus.o_sum);
        end else begin
          e = q.pop_front();
          check("o_sum",      int'(bus.o_sum), e.sum);
          check("o_cout",     int'(bus.o_cout), e.cout);
          check("o_mismatch", int'(bus.o_mismatch), e.mm);
        end
        pops++;
        prev_pop_cyc = last_pop_cyc;
        last_pop_cyc = cyc;
      end
      hold_prev = bus.o_valid && !bus.i_ready;
      prev_sum  = int'(bus.o_sum);
      prev_cout = int'(bus.o_cout);
      prev_mm   = int'(bus.o_mismatch);
      if (bus.i_valid && bus.o_ready) begin
        m_true = int'(bus.i_add_term1) + int'(bus.i_add_term2);
        m_obs  = stuck0 ? (m_true & ~1) : m_true;
        e.sum  = m_obs % (1 << W);
        e.cout = m_obs / (1 << W);
        e.mm   = (m_obs != m_true) ? 1 : 0;
        q.push_back(e);
        accepts++;
        if (e.mm == 1 && err_exp < ERR_MAX) err_exp++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic v, int a, int b);
    bus.i_valid     = v;
    bus.i_add_term1 = W'(a);
    bus.i_add_term2 = W'(b);
  endtask

  task automatic drain();
    int n;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    n = 0;
    while (q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    tick();
    tick();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0;
    drive(1'b0, 0, 0);
    bus.i_ready = 1'b1;
    bus.clear   = 1'b0;

    // Reset state
    #3;
    check("rst_o_valid", int'(bus.o_valid), 0);
    check("rst_o_ready", int'(bus.o_ready), 1);
    check("rst_o_sum",   int'(bus.o_sum), 0);
    check("rst_err_cnt", int'(bus.err_cnt), 0);
    check("rst_add_a",   int'(bus.add_a), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // 4+5: latency N+2
    drive(1'b1, 4, 5);
    @(negedge clk);
    check("lat_accept_ready", int'(bus.o_ready), 1);
    tick();
    drive(1'b0, 0, 0);
    @(negedge clk);
    check("lat_n1_valid", int'(bus.o_valid), 0);
    check("lat_add_a", int'(bus.add_a), 4);
    check("lat_add_b", int'(bus.add_b), 5);
    tick();
    @(negedge clk);
    check("lat_n2_valid", int'(bus.o_valid), 1);
    drain();

    // 15+1 carry, then back-to-back 8+8, 7+9
    drive(1'b1, 15, 1);
    tick();
    drive(1'b0, 0, 0);
    drain();
    drive(1'b1, 8, 8);
    tick();
    drive(1'b1, 7, 9);
    tick();
    drive(1'b0, 0, 0);
    drain();
    check("b2b_spacing", last_pop_cyc - prev_pop_cyc, 1);

    // Backpressure fills FIFO plus stage
    bus.i_ready = 1'b0;
    a0 = accepts;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      tick();
    end
    @(negedge clk);
    check("bp_accepts", accepts - a0, DEPTH);
    check("bp_ready_low", int'(bus.o_ready), 0);
    tick();
    bus.i_ready = 1'b1;
    @(negedge clk);
    check("bp_ready_still_low", int'(bus.o_ready), 0);
    tick();
    @(negedge clk);
    check("bp_ready_back", int'(bus.o_ready), 1);
    drain();

    // Faulty adder: mismatch counting, saturation, clear
    stuck0 = 1'b1;
    drive(1'b1, 1, 0);
    tick();
    drive(1'b0, 0, 0);
    drain();
    check("mm_err_cnt_1", int'(bus.err_cnt), err_exp);
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1, 0);
      tick();
    end
    drain();
    check("mm_err_cnt_sat", int'(bus.err_cnt), err_exp);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    err_exp = 0;
    @(negedge clk);
    check("clear_err_cnt", int'(bus.err_cnt), 0);

    // clear in the same cycle as a mismatching push
    drive(1'b1, 3, 0);
    tick();
    drive(1'b0, 0, 0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    err_exp = 0;
    drain();
    check("clear_priority", int'(bus.err_cnt), 0);

    // Random traffic, good adder then faulty adder
    for (int ph = 0; ph < 2; ph++) begin
      stuck0 = (ph == 1);
      for (int i = 0; i < 400; i++) begin
        drive(($urandom % 4) != 0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
        bus.i_ready = ($urandom % 3) != 0;
        tick();
      end
      drain();
      check("rand_err_cnt", int'(bus.err_cnt), err_exp);
    end

    // Reset mid-operation: 2 queued + 1 LOADED
    stuck0 = 1'b1;
    bus.i_ready = 1'b0;
    drive(1'b1, 1, 0);
    tick();
    tick();
    tick();
    drive(1'b0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_o_valid", int'(bus.o_valid), 0);
    check("mid_rst_err_cnt", int'(bus.err_cnt), 0);
    check("mid_rst_o_ready", int'(bus.o_ready), 1);
    check("mid_rst_o_sum",   int'(bus.o_sum), 0);
    q.delete();
    err_exp = 0;
    tick();
    rst_n = 1'b1;
    bus.i_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    check("post_rst_o_valid", int'(bus.o_valid), 0);
    check("post_rst_err_cnt", int'(bus.err_cnt), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
